pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges four stall sources into per-stage register enables, bubble/flush controls and a PC redirect strobe:
  - hazard-unit stall
  - I-cache miss
  - D-cache miss
  - multi-cycle mult/div occupancy
- Owns the mult/div busy FSM and saturating performance counters for stall and flush cycles.
- Sits between the hazard detection unit, both caches and the pipeline registers.

---
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It merges the hazard, I-cache, D-cache and mult/div stall sources into
// per-stage enables, bubble/flush controls and a PC redirect strobe.
// It also owns the mult/div busy FSM and the saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int unsigned MULDIV_LAT = 4,   // total freeze cycles per mult/div op, 1..15
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_stall,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jr,
  input  logic             muldiv_start,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0]       LAT_M1  = 4'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mdfreeze, freeze, front_stall, redirect, advance;

  // Classify the current cycle by stall/redirect priority.
  always_comb begin
    mdfreeze    = (state_q == IDLE) ? (muldiv_start & ~dcache_stall) : (cnt_q != 4'd0);
    freeze      = dcache_stall | mdfreeze;
    front_stall = ~freeze & (icache_stall | hazard_stall);
    redirect    = ~freeze & ~front_stall & (branch_taken | jump | jr);
    advance     = ~dcache_stall & ~icache_stall & ~hazard_stall;
  end

  // Per-stage controls; all outputs are held low while reset is asserted.
  always_comb begin
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    if (rst_n && !freeze) begin
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (front_stall) begin
        idex_bubble = 1'b1;
      end else begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        pc_redirect = redirect;
        ifid_flush  = redirect;
      end
    end
  end

  // Mult/div FSM next state. Once the countdown reaches zero the FSM parks in
  // BUSY until the instruction leaves EX, so a held muldiv_start cannot retrigger.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mdfreeze) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (advance) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating performance counters; clear takes precedence over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((freeze || front_stall) && stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (redirect && flush_cnt_q != '1) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign muldiv_busy = (state_q == BUSY);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (MULDIV_LAT=4, CNT_W=4).
module tb_pipeline_ctrl;

  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 4;

  // Input vector bit positions: {hazard, icache, dcache, branch, jump, jr, muldiv_start, perf_clr}
  localparam logic [7:0] I_NONE = 8'b0000_0000;
  localparam logic [7:0] I_HZ   = 8'b1000_0000;
  localparam logic [7:0] I_IC   = 8'b0100_0000;
  localparam logic [7:0] I_DC   = 8'b0010_0000;
  localparam logic [7:0] I_BR   = 8'b0001_0000;
  localparam logic [7:0] I_MD   = 8'b0000_0010;
  localparam logic [7:0] I_CLR  = 8'b0000_0001;

  // Expected control vector: {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en}
  localparam logic [7:0] E_RUN = 8'b1010_1011;
  localparam logic [7:0] E_STL = 8'b0000_1111;
  localparam logic [7:0] E_RDR = 8'b1111_1011;
  localparam logic [7:0] E_FRZ = 8'b0000_0000;

  logic clk, rst_n;
  logic hazard_stall, icache_stall, dcache_stall, branch_taken, jump, jr, muldiv_start, perf_clr;
  logic pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, muldiv_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [8:0]  sb_q[$];

  pipeline_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .hazard_stall(hazard_stall), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .branch_taken(branch_taken), .jump(jump), .jr(jr),
    .muldiv_start(muldiv_start), .perf_clr(perf_clr),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .muldiv_busy(muldiv_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] v);
    {hazard_stall, icache_stall, dcache_stall, branch_taken, jump, jr, muldiv_start, perf_clr} = v;
  endtask

  // Push the expectation, then pop it against the DUT's current outputs.
  task automatic expect_now(input string name, input logic [7:0] ectl, input logic ebusy);
    logic [8:0] exp_v, act_v;
    sb_q.push_back({ectl, ebusy});
    #1;
    exp_v = sb_q.pop_front();
    act_v = {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, muldiv_busy};
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: ctl/busy got %b required %b at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs, clock through to the next negedge.
  task automatic step(input string name, input logic [7:0] v, input logic [7:0] ectl, input logic ebusy);
    drive(v);
    expect_now(name, ectl, ebusy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string name, input logic [CW-1:0] es, input logic [CW-1:0] ef);
    n_chk++;
    if (stall_cnt !== es || flush_cnt !== ef) begin
      n_fail++;
      $display("FAIL %s: stall_cnt/flush_cnt got %0d/%0d required %0d/%0d", name, stall_cnt, flush_cnt, es, ef);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(I_NONE);
    #12;
    expect_now("reset_outputs", E_FRZ, 1'b0);
    chk_cnt("reset_counters", 4'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_run", I_NONE, E_RUN, 1'b0);
    step("idle_run2", I_NONE, E_RUN, 1'b0);
    chk_cnt("idle_counters", 4'd0, 4'd0);
  endtask

  task automatic test_hazard_branch();
    step("clr", I_CLR, E_RUN, 1'b0);
    step("hazard", I_HZ, E_STL, 1'b0);
    chk_cnt("hazard_cnt", 4'd1, 4'd0);
    step("branch", I_BR, E_RDR, 1'b0);
    chk_cnt("branch_cnt", 4'd1, 4'd1);
  endtask

  task automatic test_icache_branch();
    step("clr", I_CLR, E_RUN, 1'b0);
    for (int i = 0; i < 3; i++) step("ic_br_hold", I_IC | I_BR, E_STL, 1'b0);
    step("ic_br_redirect", I_BR, E_RDR, 1'b0);
    chk_cnt("ic_br_cnt", 4'd3, 4'd1);
  endtask

  task automatic test_muldiv();
    step("clr", I_CLR, E_RUN, 1'b0);
    step("md_accept", I_MD, E_FRZ, 1'b0);
    for (int i = 0; i < 3; i++) step("md_busy", I_MD, E_FRZ, 1'b1);
    step("md_release", I_MD, E_RUN, 1'b1);
    step("md_accept2", I_MD, E_FRZ, 1'b0);
    for (int i = 0; i < 3; i++) step("md_busy2", I_MD, E_FRZ, 1'b1);
    step("md_release2", I_NONE, E_RUN, 1'b1);
    step("md_idle", I_NONE, E_RUN, 1'b0);
    chk_cnt("md_cnt", 4'd8, 4'd0);
  endtask

  task automatic test_dcache_muldiv();
    step("clr", I_CLR, E_RUN, 1'b0);
    for (int i = 0; i < 2; i++) step("dc_md_block", I_MD | I_DC, E_FRZ, 1'b0);
    step("dc_md_accept", I_MD, E_FRZ, 1'b0);
    for (int i = 0; i < 3; i++) step("dc_md_busy", I_MD, E_FRZ, 1'b1);
    step("cnt0_icache", I_MD | I_IC, E_STL, 1'b1);
    step("cnt0_dcache", I_MD | I_DC, E_FRZ, 1'b1);
    step("cnt0_release", I_MD, E_RUN, 1'b1);
    step("dc_md_idle", I_NONE, E_RUN, 1'b0);
    chk_cnt("dc_md_cnt", 4'd8, 4'd0);
  endtask

  task automatic test_saturation();
    step("clr", I_CLR, E_RUN, 1'b0);
    for (int i = 0; i < 20; i++) step("sat_hazard", I_HZ, E_STL, 1'b0);
    chk_cnt("sat_cnt", 4'd15, 4'd0);
    step("sat_clr", I_HZ | I_CLR, E_STL, 1'b0);
    chk_cnt("sat_clr_cnt", 4'd0, 4'd0);
  endtask

  task automatic test_reset_mid_busy();
    step("rb_accept", I_MD, E_FRZ, 1'b0);
    step("rb_busy", I_MD, E_FRZ, 1'b1);
    step("rb_busy2", I_MD | I_HZ, E_FRZ, 1'b1);
    chk_cnt("rb_cnt_before", 4'd3, 4'd0);
    #1 rst_n = 1'b0;
    expect_now("rb_async_outputs", E_FRZ, 1'b0);
    chk_cnt("rb_async_cnt", 4'd0, 4'd0);
    drive(I_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    step("rb_after", I_NONE, E_RUN, 1'b0);
  endtask

  initial begin
    drive(I_NONE);
    test_reset();
    test_hazard_branch();
    test_icache_branch();
    test_muldiv();
    test_dcache_muldiv();
    test_saturation();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
